// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_e;

    // Index width that stays at least 1 bit even for degenerate N.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask) at or after ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [N-1:0] eff;
    logic [N-1:0] rot;

    always_comb begin
        int unsigned k;
        int unsigned sum;
        k   = 0;
        sum = 0;
        eff = req & ~mask;
        // Rotating the doubled vector puts the pointer position at bit 0.
        rot = N'({eff, eff} >> ptr);
        found = |rot;
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) begin
                k = i - 1;
            end
        end
        sum = int'(ptr) + k;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = found ? IW'(sum) : '0;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// N-way round-robin arbiter with bounded hold time and sticky starvation flags.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned WAIT_LIMIT = 64,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic [N-1:0]  starve
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned WW = $clog2(WAIT_LIMIT + 1);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wait_cnt [N];
    logic [N-1:0]  owner_mask;
    logic [IW-1:0] win;
    logic          found;
    logic          hold_full;

    always_comb begin
        owner_mask = '0;
        if (state == OWNED) begin
            owner_mask[gnt_id] = 1'b1;
        end
    end

    assign hold_full = (hold_cnt == HW'(MAX_HOLD));

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .mask   (owner_mask),
        .ptr    (ptr),
        .winner (win),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OWNED;
                        gnt       <= N'(1) << win;
                        gnt_valid <= 1'b1;
                        gnt_id    <= win;
                        ptr       <= IW'(rr_next(win, N));
                        hold_cnt  <= '0;
                    end
                end
                OWNED: begin
                    // Voluntary release and forced hand-off share one path; the
                    // masked pick already excludes the outgoing owner.
                    if (!req[gnt_id] || (hold_full && found)) begin
                        hold_cnt <= '0;
                        if (found) begin
                            gnt       <= N'(1) << win;
                            gnt_valid <= 1'b1;
                            gnt_id    <= win;
                            ptr       <= IW'(rr_next(win, N));
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                        end
                    end else if (!hold_full) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (wait_cnt[i] != WW'(WAIT_LIMIT)) begin
                        wait_cnt[i] <= wait_cnt[i] + WW'(1);
                    end
                    // Flag on the edge the count reaches the limit.
                    if (wait_cnt[i] >= WW'(WAIT_LIMIT - 1)) begin
                        starve[i] <= 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: default, short-hold and short-wait-limit instances.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_p, req_s;
    logic [3:0] gnt_a, gnt_p, gnt_s;
    logic       gnt_valid_a, gnt_valid_p, gnt_valid_s;
    logic [1:0] gnt_id_a, gnt_id_p, gnt_id_s;
    logic [3:0] starve_a, starve_p, starve_s;

    int n_checks = 0;
    int n_fail   = 0;

    rr_grant_arbiter #(.N(4), .MAX_HOLD(16), .WAIT_LIMIT(64)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
        .gnt_valid(gnt_valid_a), .gnt_id(gnt_id_a), .starve(starve_a)
    );

    rr_grant_arbiter #(.N(4), .MAX_HOLD(4), .WAIT_LIMIT(64)) dut_p (
        .clk(clk), .rst(rst), .req(req_p), .gnt(gnt_p),
        .gnt_valid(gnt_valid_p), .gnt_id(gnt_id_p), .starve(starve_p)
    );

    rr_grant_arbiter #(.N(4), .MAX_HOLD(8), .WAIT_LIMIT(3)) dut_s (
        .clk(clk), .rst(rst), .req(req_s), .gnt(gnt_s),
        .gnt_valid(gnt_valid_s), .gnt_id(gnt_id_s), .starve(starve_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Liveness: a pending request is served or withdrawn within the worst-case bound.
    for (genvar i = 0; i < 4; i++) begin : g_live
        assert property (@(posedge clk) disable iff (rst)
            (req_a[i] && !gnt_a[i]) |-> ##[1:52] (gnt_a[i] || !req_a[i]))
            else $error("FAIL liveness dut_a requester %0d", i);
        assert property (@(posedge clk) disable iff (rst)
            (req_p[i] && !gnt_p[i]) |-> ##[1:16] (gnt_p[i] || !req_p[i]))
            else $error("FAIL liveness dut_p requester %0d", i);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_order [5];
        exp_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        rst   = 1'b1;
        req_a = '0;
        req_p = '0;
        req_s = '0;

        // Reset state
        tick();
        check("rst_gnt_a", gnt_a, 4'b0000);
        check("rst_valid_a", gnt_valid_a, 1'b0);
        check("rst_id_a", gnt_id_a, 2'd0);
        check("rst_starve_a", starve_a, 4'b0000);
        check("rst_gnt_p", gnt_p, 4'b0000);
        check("rst_gnt_s", gnt_s, 4'b0000);
        tick();
        rst = 1'b0;

        // Single request: one-cycle latency, released to idle on drop
        req_a = 4'b0001;
        tick();
        check("single_gnt", gnt_a, 4'b0001);
        check("single_valid", gnt_valid_a, 1'b1);
        check("single_id", gnt_id_a, 2'd0);
        repeat (3) tick();
        check("single_hold", gnt_a, 4'b0001);
        req_a = 4'b0000;
        tick();
        check("single_drop_gnt", gnt_a, 4'b0000);
        check("single_drop_valid", gnt_valid_a, 1'b0);
        check("single_drop_id", gnt_id_a, 2'd0);

        // Fairness: every owner leaves after two cycles, order 0,1,2,3,0
        pulse_reset();
        req_a = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_gnt_%0d", k), gnt_a, 4'b0001 << exp_order[k]);
            check($sformatf("fair_id_%0d", k), gnt_id_a, exp_order[k]);
            tick();
            check($sformatf("fair_hold_%0d", k), gnt_a, 4'b0001 << exp_order[k]);
            req_a[exp_order[k]] = 1'b0;
            tick();
            req_a[exp_order[k]] = 1'b1;
        end
        check("fair_after_wrap", gnt_a, 4'b0010);
        req_a = 4'b0000;
        tick();
        check("fair_idle", gnt_a, 4'b0000);

        // Sole requester keeps the grant indefinitely
        req_a = 4'b0010;
        for (int k = 0; k < 50; k++) begin
            tick();
            check($sformatf("sole_gnt_%0d", k), gnt_a, 4'b0010);
        end
        check("sole_starve", starve_a, 4'b0000);
        req_a = 4'b0000;
        tick();

        // Reset mid-grant: grant drops, pointer returns to 0
        pulse_reset();
        req_a = 4'b0100;
        tick();
        check("midrst_pre_gnt", gnt_a, 4'b0100);
        check("midrst_pre_id", gnt_id_a, 2'd2);
        rst   = 1'b1;
        req_a = 4'b1111;
        tick();
        check("midrst_gnt", gnt_a, 4'b0000);
        check("midrst_valid", gnt_valid_a, 1'b0);
        rst = 1'b0;
        tick();
        check("midrst_first_gnt", gnt_a, 4'b0001);
        req_a = 4'b0000;
        tick();

        // Preemption with MAX_HOLD=4: owner keeps MAX_HOLD+1 cycles once contested
        pulse_reset();
        req_p = 4'b0001;
        tick();
        check("pre_gnt0", gnt_p, 4'b0001);
        repeat (8) tick();
        check("pre_sole_hold", gnt_p, 4'b0001);
        req_p = 4'b0101;
        tick();
        check("pre_force_gnt", gnt_p, 4'b0100);
        check("pre_force_id", gnt_id_p, 2'd2);
        check("pre_force_valid", gnt_valid_p, 1'b1);
        repeat (4) tick();
        check("pre_hold2", gnt_p, 4'b0100);
        tick();
        check("pre_regrant0", gnt_p, 4'b0001);
        check("pre_regrant0_id", gnt_id_p, 2'd0);
        repeat (4) tick();
        check("pre_hold0", gnt_p, 4'b0001);
        tick();
        check("pre_regrant2", gnt_p, 4'b0100);
        check("pre_starve", starve_p, 4'b0000);
        req_p = 4'b0000;
        tick();
        check("pre_idle", gnt_valid_p, 1'b0);

        // Starvation flag with WAIT_LIMIT=3, MAX_HOLD=8
        pulse_reset();
        req_s = 4'b0011;
        tick();
        check("stv_gnt0", gnt_s, 4'b0001);
        check("stv_e1", starve_s, 4'b0000);
        tick();
        check("stv_e2", starve_s, 4'b0000);
        tick();
        check("stv_e3", starve_s, 4'b0010);
        repeat (6) tick();
        check("stv_hold0", gnt_s, 4'b0001);
        check("stv_sticky", starve_s, 4'b0010);
        tick();
        check("stv_force_gnt", gnt_s, 4'b0010);
        check("stv_force_id", gnt_id_s, 2'd1);
        check("stv_after_grant", starve_s, 4'b0010);
        tick();
        tick();
        check("stv_w0_2", starve_s, 4'b0010);
        tick();
        check("stv_w0_3", starve_s, 4'b0011);
        req_s = 4'b0000;
        rst   = 1'b1;
        tick();
        check("stv_rst_clear", starve_s, 4'b0000);
        check("stv_rst_valid", gnt_valid_s, 1'b0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
